// File: rtl/vtg_pkg.sv
// Default 640x480@60 timing constants and the helper that turns the four
// per-axis timing values into a line or frame total.
package vtg_pkg;

   localparam int VTG_H_VISIBLE     = 640;
   localparam int VTG_H_FRONT_PORCH = 16;
   localparam int VTG_H_SYNC_PULSE  = 96;
   localparam int VTG_H_BACK_PORCH  = 48;

   localparam int VTG_V_VISIBLE     = 480;
   localparam int VTG_V_FRONT_PORCH = 10;
   localparam int VTG_V_SYNC_PULSE  = 2;
   localparam int VTG_V_BACK_PORCH  = 33;

   localparam int VTG_CNT_W         = 11;
   localparam int VTG_FRAME_CNT_W   = 16;

   function automatic int axis_total(input int visible, input int front_porch,
                                     input int sync_pulse, input int back_porch);
      return visible + front_porch + sync_pulse + back_porch;
   endfunction

   localparam int VTG_H_TOTAL = axis_total(VTG_H_VISIBLE, VTG_H_FRONT_PORCH,
                                           VTG_H_SYNC_PULSE, VTG_H_BACK_PORCH);
   localparam int VTG_V_TOTAL = axis_total(VTG_V_VISIBLE, VTG_V_FRONT_PORCH,
                                           VTG_V_SYNC_PULSE, VTG_V_BACK_PORCH);

endpackage

// File: rtl/timing_axis_counter.sv
// One axis (horizontal or vertical) of the video timing: a wrapping position
// counter whose blank/sync outputs are registered from the next count value.
module timing_axis_counter
   import vtg_pkg::*;
#(
   parameter int VISIBLE     = VTG_H_VISIBLE,
   parameter int FRONT_PORCH = VTG_H_FRONT_PORCH,
   parameter int SYNC_PULSE  = VTG_H_SYNC_PULSE,
   parameter int BACK_PORCH  = VTG_H_BACK_PORCH,
   parameter bit SYNC_POL    = 1'b0,
   parameter int CNT_W       = VTG_CNT_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             advance,
   input  logic             load_last,
   output logic [CNT_W-1:0] count,
   output logic             blank,
   output logic             sync,
   output logic             wrap,
   output logic             visible_next
);

   localparam int TOTAL = axis_total(VISIBLE, FRONT_PORCH, SYNC_PULSE, BACK_PORCH);

   // One extra bit so a region end equal to 2^CNT_W does not alias to zero.
   localparam logic [CNT_W:0] LAST       = (CNT_W+1)'(TOTAL - 1);
   localparam logic [CNT_W:0] VIS_END    = (CNT_W+1)'(VISIBLE);
   localparam logic [CNT_W:0] SYNC_BEGIN = (CNT_W+1)'(VISIBLE + FRONT_PORCH);
   localparam logic [CNT_W:0] SYNC_END   = (CNT_W+1)'(VISIBLE + FRONT_PORCH + SYNC_PULSE);
   localparam logic [CNT_W:0] ONE        = (CNT_W+1)'(1);

   if (CNT_W < 1 || CNT_W > 30 || VISIBLE < 1 || SYNC_PULSE < 1 ||
       FRONT_PORCH < 0 || BACK_PORCH < 0 || TOTAL > (1 << CNT_W)) begin : g_illegal_cfg
      $error("timing_axis_counter: illegal timing configuration");
   end

   logic [CNT_W:0] count_next;
   logic           sync_next;

   assign wrap = ({1'b0, count} == LAST);

   always_comb begin
      count_next = {1'b0, count};
      if (load_last) begin
         count_next = LAST;
      end else if (advance) begin
         count_next = wrap ? '0 : ({1'b0, count} + ONE);
      end
      visible_next = (count_next < VIS_END);
      sync_next    = (count_next >= SYNC_BEGIN) && (count_next < SYNC_END);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= LAST[CNT_W-1:0];
         blank <= 1'b1;
         sync  <= ~SYNC_POL;
      end else if (advance || load_last) begin
         count <= count_next[CNT_W-1:0];
         blank <= ~visible_next;
         sync  <= sync_next ? SYNC_POL : ~SYNC_POL;
      end
   end

endmodule

// File: rtl/video_timing_gen.sv
// Video timing generator: horizontal/vertical counters with registered sync,
// blank, de and start pulses. Define VTG_FRAME_CNT_EN to enable frame_count.
module video_timing_gen
   import vtg_pkg::*;
#(
   parameter int H_VISIBLE     = VTG_H_VISIBLE,
   parameter int H_FRONT_PORCH = VTG_H_FRONT_PORCH,
   parameter int H_SYNC_PULSE  = VTG_H_SYNC_PULSE,
   parameter int H_BACK_PORCH  = VTG_H_BACK_PORCH,
   parameter int V_VISIBLE     = VTG_V_VISIBLE,
   parameter int V_FRONT_PORCH = VTG_V_FRONT_PORCH,
   parameter int V_SYNC_PULSE  = VTG_V_SYNC_PULSE,
   parameter int V_BACK_PORCH  = VTG_V_BACK_PORCH,
   parameter int HSYNC_POL     = 0,
   parameter int VSYNC_POL     = 0,
   parameter int CNT_W         = VTG_CNT_W,
   parameter int FRAME_CNT_W   = VTG_FRAME_CNT_W
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   ce,
   output logic                   hsync,
   output logic                   vsync,
   output logic                   hblank,
   output logic                   vblank,
   output logic                   de,
   output logic [CNT_W-1:0]       h_count,
   output logic [CNT_W-1:0]       v_count,
   output logic                   line_start,
   output logic                   frame_start,
   output logic [FRAME_CNT_W-1:0] frame_count
);

   logic h_wrap;
   logic v_wrap;
   logic h_visible_next;
   logic v_visible_next;
   logic v_advance;

   assign v_advance = ce && h_wrap;

   timing_axis_counter #(
      .VISIBLE     (H_VISIBLE),
      .FRONT_PORCH (H_FRONT_PORCH),
      .SYNC_PULSE  (H_SYNC_PULSE),
      .BACK_PORCH  (H_BACK_PORCH),
      .SYNC_POL    (HSYNC_POL != 0),
      .CNT_W       (CNT_W)
   ) u_h_axis (
      .clk          (clk),
      .reset_n      (reset_n),
      .advance      (ce),
      .load_last    (1'b0),
      .count        (h_count),
      .blank        (hblank),
      .sync         (hsync),
      .wrap         (h_wrap),
      .visible_next (h_visible_next)
   );

   timing_axis_counter #(
      .VISIBLE     (V_VISIBLE),
      .FRONT_PORCH (V_FRONT_PORCH),
      .SYNC_PULSE  (V_SYNC_PULSE),
      .BACK_PORCH  (V_BACK_PORCH),
      .SYNC_POL    (VSYNC_POL != 0),
      .CNT_W       (CNT_W)
   ) u_v_axis (
      .clk          (clk),
      .reset_n      (reset_n),
      .advance      (v_advance),
      .load_last    (1'b0),
      .count        (v_count),
      .blank        (vblank),
      .sync         (vsync),
      .wrap         (v_wrap),
      .visible_next (v_visible_next)
   );

   // Start pulses mark the cycle right after a counter wrap and clear on any idle clock.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         de          <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         line_start  <= v_advance;
         frame_start <= v_advance && v_wrap;
         if (ce) begin
            de <= h_visible_next && v_visible_next;
         end
      end
   end

`ifdef VTG_FRAME_CNT_EN
   logic [FRAME_CNT_W-1:0] frame_cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt_q <= '0;
      end else if (v_advance && v_wrap) begin
         frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
      end
   end

   assign frame_count = frame_cnt_q;
`else
   assign frame_count = '0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: default 640x480 timing, a short-line
// variant for whole-frame vertical checks, and a tiny config with inverted hsync.
module tb_video_timing_gen;

`ifdef VTG_FRAME_CNT_EN
   localparam bit FC_ON = 1'b1;
`else
   localparam bit FC_ON = 1'b0;
`endif

   logic clk;
   logic reset_n_a, reset_n_b, reset_n_c;
   logic ce_a, ce_b, ce_c;

   logic        hsync_a, vsync_a, hblank_a, vblank_a, de_a, ls_a, fs_a;
   logic [10:0] h_a, v_a;
   logic [15:0] fc_a;
   logic        hsync_b, vsync_b, hblank_b, vblank_b, de_b, ls_b, fs_b;
   logic [10:0] h_b, v_b;
   logic [15:0] fc_b;
   logic        hsync_c, vsync_c, hblank_c, vblank_c, de_c, ls_c, fs_c;
   logic [10:0] h_c, v_c;
   logic [15:0] fc_c;

   int checks   = 0;
   int failures = 0;

   video_timing_gen u_dut_a (
      .clk(clk), .reset_n(reset_n_a), .ce(ce_a),
      .hsync(hsync_a), .vsync(vsync_a), .hblank(hblank_a), .vblank(vblank_a), .de(de_a),
      .h_count(h_a), .v_count(v_a), .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a)
   );

   video_timing_gen #(
      .H_VISIBLE(4), .H_FRONT_PORCH(1), .H_SYNC_PULSE(2), .H_BACK_PORCH(1)
   ) u_dut_b (
      .clk(clk), .reset_n(reset_n_b), .ce(ce_b),
      .hsync(hsync_b), .vsync(vsync_b), .hblank(hblank_b), .vblank(vblank_b), .de(de_b),
      .h_count(h_b), .v_count(v_b), .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b)
   );

   video_timing_gen #(
      .H_VISIBLE(4), .H_FRONT_PORCH(1), .H_SYNC_PULSE(2), .H_BACK_PORCH(1),
      .V_VISIBLE(3), .V_FRONT_PORCH(1), .V_SYNC_PULSE(1), .V_BACK_PORCH(1),
      .HSYNC_POL(1)
   ) u_dut_c (
      .clk(clk), .reset_n(reset_n_c), .ce(ce_c),
      .hsync(hsync_c), .vsync(vsync_c), .hblank(hblank_c), .vblank(vblank_c), .de(de_c),
      .h_count(h_c), .v_count(v_c), .line_start(ls_c), .frame_start(fs_c), .frame_count(fc_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Drive ce on one unit for a number of clocks, starting and ending on a falling edge.
   task automatic applyStimulus(input int unit, input int cycles, input bit ce_val);
      for (int i = 0; i < cycles; i++) begin
         case (unit)
            0:       ce_a = ce_val;
            1:       ce_b = ce_val;
            default: ce_c = ce_val;
         endcase
         @(negedge clk);
      end
      ce_a = 1'b0;
      ce_b = 1'b0;
      ce_c = 1'b0;
   endtask

   initial begin
      #2ms;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int exp_h, exp_v;

      reset_n_a = 1'b0; reset_n_b = 1'b0; reset_n_c = 1'b0;
      ce_a = 1'b0; ce_b = 1'b0; ce_c = 1'b0;
      repeat (3) @(negedge clk);

      checkOutput("a_rst_h", h_a, 799);
      checkOutput("a_rst_v", v_a, 524);
      checkOutput("a_rst_de", de_a, 0);
      checkOutput("a_rst_hsync", hsync_a, 1);
      checkOutput("a_rst_vsync", vsync_a, 1);
      checkOutput("a_rst_hblank", hblank_a, 1);
      checkOutput("a_rst_vblank", vblank_a, 1);
      checkOutput("a_rst_ls", ls_a, 0);
      checkOutput("a_rst_fs", fs_a, 0);
      checkOutput("a_rst_fc", fc_a, 0);
      checkOutput("b_rst_h", h_b, 7);
      checkOutput("b_rst_v", v_b, 524);
      checkOutput("c_rst_h", h_c, 7);
      checkOutput("c_rst_v", v_c, 5);
      checkOutput("c_rst_hsync", hsync_c, 0);
      checkOutput("c_rst_vsync", vsync_c, 1);

      reset_n_a = 1'b1; reset_n_b = 1'b1; reset_n_c = 1'b1;

      applyStimulus(0, 2, 1'b0);
      checkOutput("a_idle_h", h_a, 799);
      checkOutput("a_idle_ls", ls_a, 0);

      applyStimulus(0, 1, 1'b1);
      checkOutput("a_first_h", h_a, 0);
      checkOutput("a_first_v", v_a, 0);
      checkOutput("a_first_de", de_a, 1);
      checkOutput("a_first_fs", fs_a, 1);
      checkOutput("a_first_ls", ls_a, 1);
      checkOutput("a_first_fc", fc_a, FC_ON ? 1 : 0);

      applyStimulus(0, 1, 1'b0);
      checkOutput("a_hold_h", h_a, 0);
      checkOutput("a_hold_de", de_a, 1);
      checkOutput("a_hold_ls", ls_a, 0);
      checkOutput("a_hold_fs", fs_a, 0);

      for (int i = 1; i < 800; i++) begin
         applyStimulus(0, 1, 1'b1);
         checkOutput("a_line_h", h_a, i);
         checkOutput("a_line_hsync", hsync_a, (i >= 656 && i < 752) ? 0 : 1);
         checkOutput("a_line_hblank", hblank_a, (i >= 640) ? 1 : 0);
         checkOutput("a_line_de", de_a, (i < 640) ? 1 : 0);
         checkOutput("a_line_ls", ls_a, 0);
      end

      applyStimulus(0, 1, 1'b1);
      checkOutput("a_l1_h", h_a, 0);
      checkOutput("a_l1_v", v_a, 1);
      checkOutput("a_l1_ls", ls_a, 1);
      checkOutput("a_l1_fs", fs_a, 0);
      checkOutput("a_l1_de", de_a, 1);

      applyStimulus(0, 799, 1'b1);
      checkOutput("a_l1_end_h", h_a, 799);

      // ce every third clock across a line boundary
      for (int p = 0; p < 3; p++) begin
         applyStimulus(0, 1, 1'b1);
         checkOutput("a_ce3_h", h_a, p);
         checkOutput("a_ce3_v", v_a, 2);
         checkOutput("a_ce3_ls", ls_a, (p == 0) ? 1 : 0);
         applyStimulus(0, 1, 1'b0);
         checkOutput("a_ce3_h_frz1", h_a, p);
         checkOutput("a_ce3_ls_frz1", ls_a, 0);
         applyStimulus(0, 1, 1'b0);
         checkOutput("a_ce3_h_frz2", h_a, p);
         checkOutput("a_ce3_v_frz2", v_a, 2);
      end

      // Whole-frame vertical sweep on the short-line unit (8 px x 525 lines)
      applyStimulus(1, 1, 1'b1);
      checkOutput("b_first_h", h_b, 0);
      checkOutput("b_first_v", v_b, 0);
      checkOutput("b_first_fs", fs_b, 1);
      for (int k = 1; k <= 4200; k++) begin
         exp_h = k % 8;
         exp_v = (k / 8) % 525;
         applyStimulus(1, 1, 1'b1);
         checkOutput("b_h", h_b, exp_h);
         checkOutput("b_v", v_b, exp_v);
         checkOutput("b_vsync", vsync_b, (exp_v >= 490 && exp_v < 492) ? 0 : 1);
         checkOutput("b_vblank", vblank_b, (exp_v >= 480) ? 1 : 0);
         checkOutput("b_ls", ls_b, (exp_h == 0) ? 1 : 0);
         checkOutput("b_fs", fs_b, (k == 4200) ? 1 : 0);
         if (k == 4199) begin
            checkOutput("b_fc_one_frame", fc_b, FC_ON ? 1 : 0);
         end
      end
      checkOutput("b_fc_wrap", fc_b, FC_ON ? 2 : 0);

      // Tiny config, inverted hsync, reset asserted between clock edges
      applyStimulus(2, 1, 1'b1);
      checkOutput("c_first_h", h_c, 0);
      checkOutput("c_first_hsync", hsync_c, 0);
      checkOutput("c_first_de", de_c, 1);
      applyStimulus(2, 5, 1'b1);
      checkOutput("c_h5", h_c, 5);
      checkOutput("c_h5_hsync", hsync_c, 1);
      checkOutput("c_h5_de", de_c, 0);
      applyStimulus(2, 1, 1'b1);
      checkOutput("c_h6_hsync", hsync_c, 1);

      #2;
      reset_n_c = 1'b0;
      #1;
      checkOutput("c_async_h", h_c, 7);
      checkOutput("c_async_v", v_c, 5);
      checkOutput("c_async_hsync", hsync_c, 0);
      checkOutput("c_async_de", de_c, 0);
      checkOutput("c_async_hblank", hblank_c, 1);
      checkOutput("c_async_vblank", vblank_c, 1);
      @(negedge clk);
      @(negedge clk);
      checkOutput("c_held_h", h_c, 7);
      reset_n_c = 1'b1;
      applyStimulus(2, 1, 1'b0);
      checkOutput("c_rel_idle_h", h_c, 7);
      applyStimulus(2, 1, 1'b1);
      checkOutput("c_restart_h", h_c, 0);
      checkOutput("c_restart_v", v_c, 0);
      checkOutput("c_restart_fs", fs_c, 1);
      checkOutput("c_restart_ls", ls_c, 1);
      checkOutput("c_restart_de", de_c, 1);
      checkOutput("c_restart_hsync", hsync_c, 0);
      applyStimulus(2, 32, 1'b1);
      checkOutput("c_v4", v_c, 4);
      checkOutput("c_v4_vsync", vsync_c, 0);
      checkOutput("c_v4_vblank", vblank_c, 1);
      applyStimulus(2, 8, 1'b1);
      checkOutput("c_v5_vsync", vsync_c, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
